// File: rtl/pc_btb_predict_pkg.sv
// Shared constants and predictor helpers for the BTB-predicting fetch unit.
// Counters are 2-bit saturating: MSB set means predict taken.
package pc_btb_predict_pkg;

    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] NOP_INST = '0;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        unique case (1'b1)
            (taken && c != CTR_ST):   ctr_next = ctr_t'(c + 2'd1);
            (!taken && c != CTR_SNT): ctr_next = ctr_t'(c - 2'd1);
            default:                  ctr_next = c;
        endcase
    endfunction

endpackage

// File: rtl/pc_btb_predict_btb_table.sv
// Direct-mapped branch target buffer: combinational lookup port and
// a synchronous read-modify-write update port.
module btb_table
    import pc_btb_predict_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int W       = WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] lk_pc,
    output logic         lk_taken,
    output logic [W-1:0] lk_target,
    input  logic         upd_en,
    input  logic [W-1:0] upd_pc,
    input  logic         upd_taken,
    input  logic [W-1:0] upd_target
);

    localparam int IW = $clog2(ENTRIES);
    localparam int TW = W - IW - 2;

    logic [ENTRIES-1:0] valid;
    logic [TW-1:0]      tag_q    [ENTRIES];
    logic [W-1:0]       target_q [ENTRIES];
    ctr_t               ctr_q    [ENTRIES];

    logic [IW-1:0] lidx;
    logic [IW-1:0] uidx;
    logic [TW-1:0] ltag;
    logic [TW-1:0] utag;
    logic          lhit;
    logic          uhit;
    logic          unused_lsbs;

    assign lidx = lk_pc[IW+1:2];
    assign ltag = lk_pc[W-1:IW+2];
    assign uidx = upd_pc[IW+1:2];
    assign utag = upd_pc[W-1:IW+2];

    assign unused_lsbs = ^{lk_pc[1:0], upd_pc[1:0]};

    assign lhit      = valid[lidx] && (tag_q[lidx] == ltag);
    assign uhit      = valid[uidx] && (tag_q[uidx] == utag);
    assign lk_taken  = lhit && ctr_q[lidx][1];
    assign lk_target = target_q[lidx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (upd_en && upd_taken) begin
            valid[uidx] <= 1'b1;
        end
    end

    // Payload is only meaningful behind a valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (upd_en) begin
            if (uhit) begin
                ctr_q[uidx] <= ctr_next(ctr_q[uidx], upd_taken);
                if (upd_taken) begin
                    target_q[uidx] <= upd_target;
                end
            end else if (upd_taken) begin
                tag_q[uidx]    <= utag;
                target_q[uidx] <= upd_target;
                ctr_q[uidx]    <= CTR_WT;
            end
        end
    end

endmodule

// File: rtl/pc_btb_predict.sv
// Fetch-stage PC unit: BTB-driven next-pc selection and the IF-ID register.
// Priority per edge is reset, then flush, then stall, then normal advance.
module pc_btb_predict
    import pc_btb_predict_pkg::*;
#(
    parameter int           W        = WORD_WIDTH,
    parameter int           ENTRIES  = 16,
    parameter logic [W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic [W-1:0] flush_addr,
    output logic [W-1:0] pc,
    input  logic [W-1:0] read_inst,
    output logic [W-1:0] inst,
    output logic [W-1:0] id_pc,
    output logic         id_pred_taken,
    output logic [W-1:0] id_pred_target,
    input  logic         upd_en,
    input  logic [W-1:0] upd_pc,
    input  logic         upd_taken,
    input  logic [W-1:0] upd_target
);

    logic         pred_taken;
    logic [W-1:0] btb_target;
    logic [W-1:0] next_pc;

    btb_table #(
        .ENTRIES (ENTRIES),
        .W       (W)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .lk_pc      (pc),
        .lk_taken   (pred_taken),
        .lk_target  (btb_target),
        .upd_en     (upd_en),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    assign next_pc = pred_taken ? btb_target : pc + W'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= RESET_PC;
            inst           <= W'(NOP_INST);
            id_pc          <= '0;
            id_pred_taken  <= 1'b0;
            id_pred_target <= '0;
        end else if (flush) begin
            pc            <= flush_addr;
            inst          <= W'(NOP_INST);
            id_pc         <= '0;
            id_pred_taken <= 1'b0;
        end else if (!stall) begin
            pc             <= next_pc;
            inst           <= read_inst;
            id_pc          <= pc;
            id_pred_taken  <= pred_taken;
            id_pred_target <= next_pc;
        end
    end

endmodule

// File: tb/tb_pc_btb_predict.sv
// Directed bench for pc_btb_predict with a per-cycle reference model.
module tb_pc_btb_predict;

    localparam logic [31:0] RST_PC = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_addr = '0;
    logic [31:0] pc;
    logic [31:0] read_inst;
    logic [31:0] inst;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;
    logic        upd_en = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;

    int errors = 0;
    int checks = 0;

    pc_btb_predict #(
        .W        (32),
        .ENTRIES  (16),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .flush_addr     (flush_addr),
        .pc             (pc),
        .read_inst      (read_inst),
        .inst           (inst),
        .id_pc          (id_pc),
        .id_pred_taken  (id_pred_taken),
        .id_pred_target (id_pred_target),
        .upd_en         (upd_en),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target)
    );

    always #5 clk = ~clk;

    assign read_inst = {pc[15:0], 16'h0013};

    // Reference model: BTB as plain arrays indexed by word address mod 16.
    logic [31:0] m_pc, m_inst, m_id_pc, m_tgt_out;
    logic        m_taken_out;
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a / 4) % 16;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a / 64;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int unsigned i, j;
        bit          pt;
        logic [31:0] np;
        if (rst) begin
            m_pc = RST_PC;
            m_inst = 0;
            m_id_pc = 0;
            m_taken_out = 0;
            m_tgt_out = 0;
            for (int k = 0; k < 16; k++) m_valid[k] = 0;
        end else begin
            i = idx_of(m_pc);
            pt = m_valid[i] && m_tag[i] == tag_of(m_pc) && m_ctr[i] >= 2;
            np = pt ? m_tgt[i] : m_pc + 32'd4;
            if (upd_en) begin
                j = idx_of(upd_pc);
                if (m_valid[j] && m_tag[j] == tag_of(upd_pc)) begin
                    if (upd_taken) begin
                        m_ctr[j] = (m_ctr[j] < 3) ? m_ctr[j] + 1 : 3;
                        m_tgt[j] = upd_target;
                    end else begin
                        m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
                    end
                end else if (upd_taken) begin
                    m_valid[j] = 1;
                    m_tag[j] = tag_of(upd_pc);
                    m_tgt[j] = upd_target;
                    m_ctr[j] = 2;
                end
            end
            if (flush) begin
                m_pc = flush_addr;
                m_inst = 0;
                m_id_pc = 0;
                m_taken_out = 0;
            end else if (!stall) begin
                m_inst = {m_pc[15:0], 16'h0013};
                m_id_pc = m_pc;
                m_taken_out = pt;
                m_tgt_out = np;
                m_pc = np;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m.pc", pc, m_pc);
        chk("m.inst", inst, m_inst);
        chk("m.id_pc", id_pc, m_id_pc);
        chk("m.taken", {31'b0, id_pred_taken}, {31'b0, m_taken_out});
        chk("m.target", id_pred_target, m_tgt_out);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic upd(input logic [31:0] a, input logic t,
                       input logic [31:0] tg);
        upd_en = 1'b1;
        upd_pc = a;
        upd_taken = t;
        upd_target = tg;
        step();
        upd_en = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] a);
        flush = 1'b1;
        flush_addr = a;
        step();
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst.pc", pc, 32'h100);
        chk("rst.inst", inst, 32'h0);
        step();
        chk("t1.pc1", pc, 32'h104);
        chk("t1.inst1", inst, 32'h0100_0013);
        chk("t1.idpc1", id_pc, 32'h100);
        step();
        step();
        chk("t1.pc3", pc, 32'h10C);
        chk("t1.idpc3", id_pc, 32'h108);

        stall = 1'b1;
        upd(32'h10C, 1'b1, 32'h200);
        stall = 1'b0;
        chk("t2.hold", pc, 32'h10C);
        step();
        chk("t2.pc", pc, 32'h200);
        chk("t2.taken", {31'b0, id_pred_taken}, 32'd1);
        chk("t2.target", id_pred_target, 32'h200);
        chk("t2.idpc", id_pc, 32'h10C);

        stall = 1'b1;
        repeat (3) upd(32'h10C, 1'b0, 32'h0);
        stall = 1'b0;
        redirect(32'h10C);
        chk("t3.flpc", pc, 32'h10C);
        step();
        chk("t3.nt_pc", pc, 32'h110);
        chk("t3.nt_taken", {31'b0, id_pred_taken}, 32'd0);
        chk("t3.nt_target", id_pred_target, 32'h110);
        stall = 1'b1;
        repeat (4) upd(32'h10C, 1'b1, 32'h200);
        upd(32'h10C, 1'b0, 32'h0);
        stall = 1'b0;
        redirect(32'h10C);
        step();
        chk("t3.sat_pc", pc, 32'h200);

        stall = 1'b1;
        upd(32'h14C, 1'b1, 32'h400);
        stall = 1'b0;
        redirect(32'h10C);
        step();
        chk("t4.alias_miss", pc, 32'h110);
        redirect(32'h14C);
        step();
        chk("t4.alias_hit", pc, 32'h400);

        stall = 1'b1;
        redirect(32'h300);
        chk("t5.pc", pc, 32'h300);
        chk("t5.inst", inst, 32'h0);
        chk("t5.idpc", id_pc, 32'h0);
        stall = 1'b0;
        step();
        chk("t5.adv_inst", inst, 32'h0300_0013);
        stall = 1'b1;
        step();
        step();
        chk("t5.st_pc", pc, 32'h304);
        chk("t5.st_inst", inst, 32'h0300_0013);
        chk("t5.st_idpc", id_pc, 32'h300);
        stall = 1'b0;

        #2 rst = 1'b1;
        #1;
        chk("t6.arst_pc", pc, 32'h100);
        chk("t6.arst_inst", inst, 32'h0);
        chk("t6.arst_idpc", id_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        redirect(32'h14C);
        step();
        chk("t6.cleared", pc, 32'h150);
        redirect(32'h10C);
        upd(32'h10C, 1'b1, 32'h200);
        chk("t6.same_cyc", pc, 32'h110);
        chk("t6.same_taken", {31'b0, id_pred_taken}, 32'd0);
        redirect(32'h10C);
        step();
        chk("t6.next", pc, 32'h200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
